enc_16x4_chk: RTL and testbench
===============================

# enc_16x4_chk

Registered 16-to-4 priority encoder with a built-in decoder sweep checker; the inverse of the 4x16 decoder family. It accepts 16-line decoder output words over a valid/ready handshake and returns the 4-bit code {X,Y,Z,W} plus one-hot error flags. In sweep mode it compares 16 consecutive words against the expected one-hot pattern for codes 0..15 and builds a per-line fault map. It sits downstream of a decoder under test, including fault-injected variants.

## Interface
Parameters: none; widths are fixed at 16 lines and 4 code bits.

- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  D word present
- in_ready  output  1  block can accept D this cycle
- D  input  16  decoder output word, D[i] is line i
- out_valid  output  1  encoded result held in output register
- out_ready  input  1  consumer takes result
- X,Y,Z,W  output  1 each  encoded index, X = MSB, W = LSB
- err_zero  output  1  accepted word had no bit set
- err_multi  output  1  accepted word had more than one bit set
- start  input  1  single-cycle pulse to begin a sweep
- busy  output  1  sweep in progress
- done  output  1  sweep complete; level, held until next start or reset
- fault_map  output  16  bit k set = sweep word k did not equal 1<<k

## Operation
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready, combinational, no bubble.
- Encode on accept, registered:
  - {X,Y,Z,W} = index of the highest set bit of D; 0 when D==0.
  - err_zero = (D==0).
  - err_multi = popcount(D) > 1.
- Output register holds its value while out_valid && !out_ready.
- Sweep FSM has three states: IDLE, SWEEP, DONE.
  - IDLE or DONE + start: go to SWEEP. Set cnt=0 and clear fault_map to 0. done=0.
  - SWEEP + accept: if D != (16'h1 << cnt), set fault_map[cnt]. Then cnt++.
  - SWEEP + accept with cnt==15: go to DONE. done=1.
  - start while in SWEEP is ignored. The sweep is not restarted.
  - fault_map is sticky within a sweep and holds in DONE.
- Encoding runs in every state. The sweep only observes accepted words; it never stalls the handshake.
- busy = (state==SWEEP).

## Timing
- Reset (async assert, clocked release) sets:
  - out_valid=0, X=Y=Z=W=0, err_zero=0, err_multi=0
  - state=IDLE, cnt=0, fault_map=0, done=0, busy=0
  - in_ready=1 from the first cycle after reset.
- Latency is 1 cycle: a word accepted at edge n is visible on the outputs after edge n.
- Throughput is 1 word per cycle when out_ready is held high.
- start is sampled on the same edge as an accept:
  - In IDLE or DONE, the FSM enters SWEEP on that edge. That word is not checked; the first checked word is the next accept.
  - In SWEEP on the cnt==15 accept, start is ignored and the FSM enters DONE.
- done and fault_map update on the edge of the 16th accepted sweep word. This is the same edge on which its encoded result loads.
- Reset mid-sweep aborts the sweep, clears fault_map, and returns to IDLE.
- cnt is 4 bits. It never wraps inside a sweep, because the FSM leaves SWEEP at 15.

## Structure
- Shared package: line count 16, code width 4, and the FSM state encoding (IDLE/SWEEP/DONE).
- One sub-module, enc_16x4_prio: combinational priority encoder producing the index, zero flag and multi flag. The top level holds the handshake register, sweep FSM, cnt and fault_map.
- Target size is about 150–250 lines.

## Test plan
- Encode each D = 1<<i for i=0..15 with out_ready=1. Required: {X,Y,Z,W}=i one cycle later, err_zero=0, err_multi=0, one result per cycle.
- Send D=16'h0000, then D=16'h8101. Required: code 0 with err_zero=1, then code 15 with err_multi=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. Required: in_ready=0 after the first accept, the output is stable, and no word is lost or duplicated once out_ready=1.
- Sweep with a healthy pattern (word k = 1<<k): start, then 16 words. Required: busy for 16 accepts, then done=1 and fault_map=16'h0000.
- Sweep against the stuck-line decoder (word 8 = 0). Required: done=1, fault_map=16'h0100, and err_zero seen on the 9th result.
- Assert rst after 5 sweep words, then start again. Required: fault_map=0, done=0, and the full sweep completes normally. Also pulse start during SWEEP and confirm it is ignored (cnt is not reset).

Source files
------------

// File: rtl/enc_16x4_chk_pkg.sv
// Shared widths and sweep FSM encoding for the 16-to-4 encoder/checker.
package enc_16x4_chk_pkg;
  localparam int NUM_LINES = 16;
  localparam int CODE_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_t;
endpackage

// File: rtl/enc_16x4_prio.sv
// Combinational 16-to-4 priority encoder: highest set line wins, plus
// zero and multi-hot flags.
module enc_16x4_prio
  import enc_16x4_chk_pkg::*;
(
  input  logic [NUM_LINES-1:0] d,
  output logic [CODE_W-1:0]    idx,
  output logic                 zero,
  output logic                 multi
);

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (d[i]) idx = CODE_W'(i);
    end
  end

  assign zero  = (d == '0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = ((d & (d - NUM_LINES'(1))) != '0);

endmodule

// File: rtl/enc_16x4_chk.sv
// Registered 16-to-4 priority encoder with valid/ready handshake and a
// 16-word decoder sweep checker that builds a per-line fault map.
module enc_16x4_chk
  import enc_16x4_chk_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_LINES-1:0] D,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 X,
  output logic                 Y,
  output logic                 Z,
  output logic                 W,
  output logic                 err_zero,
  output logic                 err_multi,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_LINES-1:0] fault_map
);

  logic [CODE_W-1:0] idx;
  logic              zero;
  logic              multi;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] cnt;
  logic              accept;
  logic              last_word;
  sweep_state_t      state, state_nxt;

  enc_16x4_prio u_prio (
    .d     (D),
    .idx   (idx),
    .zero  (zero),
    .multi (multi)
  );

  // A pending result may be replaced in the same cycle it is consumed.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_word = (cnt == CODE_W'(NUM_LINES - 1));
  assign {X, Y, Z, W} = code_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      code_q    <= '0;
      err_zero  <= 1'b0;
      err_multi <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      code_q    <= idx;
      err_zero  <= zero;
      err_multi <= multi;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_SWEEP;
      ST_SWEEP:         if (accept && last_word) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The word accepted alongside start is not checked; checking begins on
  // the next accept. cnt rolls to 0 only as the FSM leaves SWEEP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      fault_map <= '0;
    end else if (state != ST_SWEEP && start) begin
      cnt       <= '0;
      fault_map <= '0;
    end else if (state == ST_SWEEP && accept) begin
      if (D != (NUM_LINES'(1) << cnt)) fault_map[cnt] <= 1'b1;
      cnt <= cnt + CODE_W'(1);
    end
  end

  assign busy = (state == ST_SWEEP);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_enc_16x4_chk.sv
// Self-checking bench for enc_16x4_chk: table-driven encode vectors, a
// result scoreboard, and hand-written backpressure and sweep sequences.
module tb_enc_16x4_chk;

  typedef struct packed {
    logic [3:0] code;
    logic       ez;
    logic       em;
  } exp_t;

  typedef struct packed {
    logic [15:0] d;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] D = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        X, Y, Z, W;
  logic        err_zero, err_multi;
  logic        start = 1'b0;
  logic        busy, done;
  logic [15:0] fault_map;

  int total = 0;
  int bad   = 0;

  exp_t        sb_q[$];
  logic        m_ov;
  int          m_state;   // 0 idle, 1 sweep, 2 done
  int          m_cnt;
  logic [15:0] m_fmap;

  vec_t vecs[20];
  exp_t dummy = '0;

  enc_16x4_chk dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X         (X),
    .Y         (Y),
    .Z         (Z),
    .W         (W),
    .err_zero  (err_zero),
    .err_multi (err_multi),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fault_map (fault_map)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t model_enc(input logic [15:0] d);
    exp_t r;
    int   n;
    r = '0;
    n = 0;
    for (int i = 15; i >= 0; i--) begin
      if (d[i]) begin
        if (n == 0) r.code = i[3:0];
        n++;
      end
    end
    r.ez = (n == 0);
    r.em = (n > 1);
    return r;
  endfunction

  // Called at posedge+1: drives one cycle of stimulus, checks the DUT
  // mid-cycle against the bench model, then advances the model and clock.
  task automatic step(input logic v, input logic [15:0] d, input logic ordy,
                      input logic st, input exp_t e);
    logic acc;
    in_valid  = v;
    D         = d;
    out_ready = ordy;
    start     = st;
    #4;
    check("in_ready", {31'b0, in_ready}, {31'b0, !m_ov || ordy});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    check("busy", {31'b0, busy}, {31'b0, m_state == 1});
    check("done", {31'b0, done}, {31'b0, m_state == 2});
    check("fault_map", {16'b0, fault_map}, {16'b0, m_fmap});
    if (m_ov) begin
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        check("result", {26'b0, X, Y, Z, W, err_zero, err_multi},
              {26'b0, sb_q[0].code, sb_q[0].ez, sb_q[0].em});
        if (ordy) void'(sb_q.pop_front());
      end
    end
    acc = v && (!m_ov || ordy);
    if (acc) sb_q.push_back(e);
    m_ov = acc || (m_ov && !ordy);
    if (m_state != 1 && st) begin
      m_state = 1;
      m_cnt   = 0;
      m_fmap  = '0;
    end else if (m_state == 1 && acc) begin
      if (d != (16'h1 << m_cnt)) m_fmap[m_cnt] = 1'b1;
      if (m_cnt == 15) m_state = 2;
      m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_code_err", {26'b0, X, Y, Z, W, err_zero, err_multi}, 32'd0);
    check("rst_busy_done", {30'b0, busy, done}, 32'd0);
    check("rst_fault_map", {16'b0, fault_map}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_ov    = 1'b0;
    m_state = 0;
    m_cnt   = 0;
    m_fmap  = '0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  // Word k = 1<<k except at bad_k (forced to 0); start re-pulsed at mid_start.
  task automatic sweep(input int bad_k, input int mid_start);
    logic [15:0] w;
    step(1'b1, 16'h0001, 1'b1, 1'b1, model_enc(16'h0001));
    for (int k = 0; k < 16; k++) begin
      w = (k == bad_k) ? 16'h0000 : (16'h1 << k);
      step(1'b1, w, 1'b1, (k == mid_start), model_enc(w));
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, dummy);
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      vecs[i] = '{d: 16'h1 << i, e: '{code: i[3:0], ez: 1'b0, em: 1'b0}};
    vecs[16] = '{d: 16'h0000, e: '{code: 4'd0,  ez: 1'b1, em: 1'b0}};
    vecs[17] = '{d: 16'h8101, e: '{code: 4'd15, ez: 1'b0, em: 1'b1}};
    vecs[18] = '{d: 16'hFFFF, e: '{code: 4'd15, ez: 1'b0, em: 1'b1}};
    vecs[19] = '{d: 16'h0006, e: '{code: 4'd2,  ez: 1'b0, em: 1'b1}};

    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back encode at full throughput.
    foreach (vecs[i]) step(1'b1, vecs[i].d, 1'b1, 1'b0, vecs[i].e);
    step(1'b0, 16'h0000, 1'b1, 1'b0, dummy);

    // Backpressure: A accepted, B held for 3 stalled cycles, then released.
    step(1'b1, 16'h0010, 1'b1, 1'b0, model_enc(16'h0010));
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0400, 1'b0, 1'b0, model_enc(16'h0400));
    step(1'b1, 16'h0400, 1'b1, 1'b0, model_enc(16'h0400));
    step(1'b0, 16'h0000, 1'b1, 1'b0, dummy);
    check("bp_drained", sb_q.size(), 32'd0);

    // Healthy sweep.
    sweep(-1, -1);
    check("healthy_done", {31'b0, done}, 32'd1);
    check("healthy_map", {16'b0, fault_map}, 32'h0000);

    // Stuck line 8.
    sweep(8, -1);
    check("stuck_done", {31'b0, done}, 32'd1);
    check("stuck_map", {16'b0, fault_map}, 32'h0100);

    // Reset after 5 sweep words (word 2 faulty), then a clean sweep with a
    // start pulse mid-sweep that must be ignored.
    step(1'b1, 16'h0001, 1'b1, 1'b1, model_enc(16'h0001));
    for (int k = 0; k < 5; k++)
      step(1'b1, (k == 2) ? 16'h0000 : (16'h1 << k), 1'b1, 1'b0,
           model_enc((k == 2) ? 16'h0000 : (16'h1 << k)));
    check("pre_rst_map", {16'b0, fault_map}, 32'h0004);
    do_reset();
    check("post_rst_done", {31'b0, done}, 32'd0);
    sweep(-1, 5);
    check("restart_done", {31'b0, done}, 32'd1);
    check("restart_map", {16'b0, fault_map}, 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
